// File: rtl/ctr_game_driver.sv
// Player-side driver for the 3-bit game counter: loads the seed, streams queued step
// commands into the counter, tallies its WINNER/LOSER pulses and cross-checks the verdict.
module ctr_game_driver #(
  parameter int unsigned COUNTER_SIZE = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [1:0]  IDLE_CTRL    = 2'b00,
  parameter int unsigned TALLY_MAX    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [COUNTER_SIZE-1:0] seed,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_data,
  output logic                    cmd_ready,
  output logic [1:0]              control,
  output logic                    init,
  output logic [COUNTER_SIZE-1:0] initial_value,
  input  logic                    winner,
  input  logic                    loser,
  input  logic                    gameover,
  input  logic [1:0]              who,
  output logic                    busy,
  output logic [3:0]              win_tally,
  output logic [3:0]              lose_tally,
  output logic                    result_valid,
  output logic [1:0]              result_who,
  output logic                    mismatch,
  output logic [7:0]              games_won,
  output logic [7:0]              games_lost
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  TallyMax = 4'(TALLY_MAX);
  localparam logic [3:0]  TallySat = 4'hF;
  localparam logic [7:0]  GamesSat = 8'hFF;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StReport} state_e;

  state_e state_q, state_d;

  // Command FIFO; pointers carry one extra bit to tell full from empty.
  logic [1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full, push, pop;
  logic [1:0]    fifo_head;

  logic [COUNTER_SIZE-1:0] seed_q, seed_d;
  logic [COUNTER_SIZE-1:0] initial_value_q, initial_value_d;
  logic [1:0]              control_q, control_d;
  logic                    init_q, init_d;
  logic [3:0]              win_tally_q, win_tally_d, lose_tally_q, lose_tally_d;
  logic [1:0]              who_q, who_d;
  logic                    mismatch_q, mismatch_d;
  logic [7:0]              games_won_q, games_won_d, games_lost_q, games_lost_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[PtrW-1:0]];
  assign cmd_ready  = !fifo_full && !reset;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == StRun) && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= cmd_data;
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StRun;
      StRun:    if (gameover) state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs and datapath next values
  always_comb begin
    seed_d          = seed_q;
    init_d          = 1'b0;
    initial_value_d = initial_value_q;
    control_d       = IDLE_CTRL;
    win_tally_d     = win_tally_q;
    lose_tally_d    = lose_tally_q;
    who_d           = who_q;
    mismatch_d      = mismatch_q;
    games_won_d     = games_won_q;
    games_lost_d    = games_lost_q;

    unique case (state_q)
      StIdle: begin
        if (start) seed_d = seed;
      end
      StLoad: begin
        init_d          = 1'b1;
        initial_value_d = seed_q;
        win_tally_d     = '0;
        lose_tally_d    = '0;
      end
      StRun: begin
        if (pop) control_d = fifo_head;
        if (winner && win_tally_q != TallySat)  win_tally_d  = win_tally_q + 4'd1;
        if (loser && lose_tally_q != TallySat)  lose_tally_d = lose_tally_q + 4'd1;
        if (winner && loser) mismatch_d = 1'b1;
        if (gameover) who_d = who;
      end
      StReport: begin
        unique case (who_q)
          2'b10: begin
            if (games_won_q != GamesSat) games_won_d = games_won_q + 8'd1;
            if (win_tally_q != TallyMax) mismatch_d = 1'b1;
          end
          2'b01: begin
            if (games_lost_q != GamesSat) games_lost_d = games_lost_q + 8'd1;
            if (lose_tally_q != TallyMax) mismatch_d = 1'b1;
          end
          default: mismatch_d = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seed_q          <= '0;
      init_q          <= 1'b0;
      initial_value_q <= '0;
      control_q       <= IDLE_CTRL;
      win_tally_q     <= '0;
      lose_tally_q    <= '0;
      who_q           <= '0;
      mismatch_q      <= 1'b0;
      games_won_q     <= '0;
      games_lost_q    <= '0;
    end else begin
      seed_q          <= seed_d;
      init_q          <= init_d;
      initial_value_q <= initial_value_d;
      control_q       <= control_d;
      win_tally_q     <= win_tally_d;
      lose_tally_q    <= lose_tally_d;
      who_q           <= who_d;
      mismatch_q      <= mismatch_d;
      games_won_q     <= games_won_d;
      games_lost_q    <= games_lost_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign result_valid  = (state_q == StReport);
  assign result_who    = who_q;
  assign control       = control_q;
  assign init          = init_q;
  assign initial_value = initial_value_q;
  assign win_tally     = win_tally_q;
  assign lose_tally    = lose_tally_q;
  assign mismatch      = mismatch_q;
  assign games_won     = games_won_q;
  assign games_lost    = games_lost_q;

  // Both strobes are single-cycle by construction of the state sequence.
  a_init_pulse : assert property (@(posedge clock) init |=> !init);
  a_result_pulse : assert property (@(posedge clock) result_valid |=> !result_valid);

endmodule

// File: tb/tb_ctr_game_driver.sv
// Directed bench for ctr_game_driver: a cycle table for reset/load/command order, then
// hand sequences for backpressure, win/lose verdicts, mismatch and mid-game reset.
module tb_ctr_game_driver;

  logic       clock = 1'b0;
  logic       reset, start, cmd_valid, winner, loser, gameover;
  logic [2:0] seed, initial_value;
  logic [1:0] cmd_data, who, control, result_who;
  logic       cmd_ready, init, busy, result_valid, mismatch;
  logic [3:0] win_tally, lose_tally;
  logic [7:0] games_won, games_lost;

  int errors = 0;
  int checks = 0;

  ctr_game_driver dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .control(control), .init(init), .initial_value(initial_value),
    .winner(winner), .loser(loser), .gameover(gameover), .who(who),
    .busy(busy), .win_tally(win_tally), .lose_tally(lose_tally),
    .result_valid(result_valid), .result_who(result_who), .mismatch(mismatch),
    .games_won(games_won), .games_lost(games_lost)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst; logic st; logic [2:0] sd; logic cv; logic [1:0] cd;
    logic w; logic l; logic go; logic [1:0] wh;
    logic e_busy; logic e_init; logic [2:0] e_iv; logic [1:0] e_ctrl; logic e_ready;
    logic e_rv; logic [1:0] e_rwho; logic [3:0] e_wt; logic [3:0] e_lt; logic e_mm;
    logic [7:0] e_gw; logic [7:0] e_gl;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; start = 1'b0; seed = 3'd0; cmd_valid = 1'b0; cmd_data = 2'b00;
    winner = 1'b0; loser = 1'b0; gameover = 1'b0; who = 2'b00;
  endtask

  initial begin
    logic [1:0] bp [5];
    logic [1:0] ctrl_exp [4];

    // rst st sd cv cd w l go wh | busy init iv ctrl ready rv rwho wt lt mm gw gl
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b1, 3'd5, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b0, 3'd5, 2'b01, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b0, 3'd5, 2'b10, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b0, 3'd5, 2'b11, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, 1'b0, 3'd5, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};

    bp[0] = 2'b00; bp[1] = 2'b01; bp[2] = 2'b10; bp[3] = 2'b11; bp[4] = 2'b01;
    ctrl_exp[0] = 2'b10; ctrl_exp[1] = 2'b11; ctrl_exp[2] = 2'b01; ctrl_exp[3] = 2'b00;

    clear_inputs();

    // Reset, seed load and command order, one table row per clock
    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; seed = vecs[i].sd;
      cmd_valid = vecs[i].cv; cmd_data = vecs[i].cd;
      winner = vecs[i].w; loser = vecs[i].l; gameover = vecs[i].go; who = vecs[i].wh;
      step();
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("row%0d init", i), 32'(init), 32'(vecs[i].e_init));
      chk($sformatf("row%0d initial_value", i), 32'(initial_value), 32'(vecs[i].e_iv));
      chk($sformatf("row%0d control", i), 32'(control), 32'(vecs[i].e_ctrl));
      chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_ready));
      chk($sformatf("row%0d result_valid", i), 32'(result_valid), 32'(vecs[i].e_rv));
      chk($sformatf("row%0d result_who", i), 32'(result_who), 32'(vecs[i].e_rwho));
      chk($sformatf("row%0d win_tally", i), 32'(win_tally), 32'(vecs[i].e_wt));
      chk($sformatf("row%0d lose_tally", i), 32'(lose_tally), 32'(vecs[i].e_lt));
      chk($sformatf("row%0d mismatch", i), 32'(mismatch), 32'(vecs[i].e_mm));
      chk($sformatf("row%0d games_won", i), 32'(games_won), 32'(vecs[i].e_gw));
      chk($sformatf("row%0d games_lost", i), 32'(games_lost), 32'(vecs[i].e_gl));
    end
    clear_inputs();

    // Win path: 16 winner pulses (last one saturates), then who=10
    winner = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("win_tally after %0d pulses", i), 32'(win_tally), (i > 15) ? 32'd15 : i);
    end
    winner = 1'b0; gameover = 1'b1; who = 2'b10;
    step();
    chk("win report result_valid", 32'(result_valid), 32'd1);
    chk("win report result_who", 32'(result_who), 32'd2);
    chk("win report busy", 32'(busy), 32'd1);
    gameover = 1'b0; who = 2'b00;
    step();
    chk("win done result_valid", 32'(result_valid), 32'd0);
    chk("win done games_won", 32'(games_won), 32'd1);
    chk("win done mismatch", 32'(mismatch), 32'd0);
    chk("win done win_tally held", 32'(win_tally), 32'd15);
    chk("win done busy", 32'(busy), 32'd0);

    // Backpressure: four accepted, fifth held until the FIFO drains
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_data = bp[i];
      chk($sformatf("bp cmd_ready before push %0d", i), 32'(cmd_ready), 32'd1);
      step();
    end
    cmd_data = bp[4];
    chk("bp cmd_ready full", 32'(cmd_ready), 32'd0);
    step();
    chk("bp cmd_ready still full", 32'(cmd_ready), 32'd0);
    start = 1'b1; seed = 3'd2;
    step();
    chk("bp load busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("bp init", 32'(init), 32'd1);
    chk("bp initial_value", 32'(initial_value), 32'd2);
    chk("bp cmd_ready in first run cycle", 32'(cmd_ready), 32'd0);
    step();
    chk("bp control pop0", 32'(control), 32'd0);
    chk("bp cmd_ready after first pop", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp control pop1", 32'(control), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp control drain %0d", i), 32'(control), 32'(ctrl_exp[i]));
    end

    // Lose verdict with a short tally: counted but flagged
    loser = 1'b1;
    repeat (3) step();
    chk("lose lose_tally", 32'(lose_tally), 32'd3);
    loser = 1'b0; gameover = 1'b1; who = 2'b01;
    step();
    chk("lose report result_valid", 32'(result_valid), 32'd1);
    chk("lose report result_who", 32'(result_who), 32'd1);
    gameover = 1'b0; who = 2'b00;
    step();
    chk("lose games_lost", 32'(games_lost), 32'd1);
    chk("lose games_won kept", 32'(games_won), 32'd1);
    chk("lose mismatch", 32'(mismatch), 32'd1);
    winner = 1'b1; gameover = 1'b1; who = 2'b10;
    step();
    chk("idle ignores gameover", 32'(result_valid), 32'd0);
    chk("idle ignores winner", 32'(win_tally), 32'd0);
    chk("mismatch sticky", 32'(mismatch), 32'd1);
    clear_inputs();

    // Reset clears mismatch; simultaneous pulses set it again
    reset = 1'b1;
    step();
    chk("reset2 mismatch", 32'(mismatch), 32'd0);
    chk("reset2 games_won", 32'(games_won), 32'd0);
    chk("reset2 games_lost", 32'(games_lost), 32'd0);
    chk("reset2 lose_tally", 32'(lose_tally), 32'd0);
    reset = 1'b0; start = 1'b1; seed = 3'd7;
    step();
    start = 1'b0;
    step();
    winner = 1'b1; loser = 1'b1;
    step();
    chk("both win_tally", 32'(win_tally), 32'd1);
    chk("both lose_tally", 32'(lose_tally), 32'd1);
    chk("both mismatch", 32'(mismatch), 32'd1);
    loser = 1'b0;
    step();
    chk("run win_tally 2", 32'(win_tally), 32'd2);

    // Reset mid-run aborts with no result
    winner = 1'b0; reset = 1'b1;
    step();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort win_tally", 32'(win_tally), 32'd0);
    chk("abort lose_tally", 32'(lose_tally), 32'd0);
    chk("abort mismatch", 32'(mismatch), 32'd0);
    chk("abort initial_value", 32'(initial_value), 32'd0);
    reset = 1'b0;
    step();
    chk("abort no result", 32'(result_valid), 32'd0);
    chk("abort cmd_ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctr_game_driver.md
Name: ctr_game_driver

Overview:
- Player-side controller for the 3-bit game counter.
- Sequences one game: loads the seed, streams up/down step commands from a small command FIFO into the counter's control input, and tallies the counter's WINNER/LOSER pulses.
- On GAMEOVER, checks that the counter's WHO verdict matches its own tally, then publishes a one-cycle result and updates saturating match scores.
- Sits between the stimulus/UI source (valid/ready) and the counter.

Parameters:
- COUNTER_SIZE, 3, width of counter seed/initial value.
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2).
- IDLE_CTRL, 2'b00, control value driven when no command is available.
- TALLY_MAX, 15, win/lose pulse count that ends a game.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a game (sampled only in IDLE)
- seed  in  COUNTER_SIZE  initial counter value for the game
- cmd_valid  in  1  command present
- cmd_data  in  2  step command: 00 +1, 01 +2, 10 −1, 11 −2
- cmd_ready  out  1  FIFO can accept
- control  out  2  counter step control (registered)
- init  out  1  counter load strobe (registered)
- initial_value  out  COUNTER_SIZE  counter load value (registered)
- winner  in  1  counter WINNER pulse
- loser  in  1  counter LOSER pulse
- gameover  in  1  counter GAMEOVER
- who  in  2  counter verdict: 01 loser, 10 winner
- busy  out  1  state ≠ IDLE
- win_tally  out  4  winner pulses this game
- lose_tally  out  4  loser pulses this game
- result_valid  out  1  one-cycle result strobe
- result_who  out  2  verdict latched with result_valid
- mismatch  out  1  sticky consistency error
- games_won  out  8  saturating
- games_lost  out  8  saturating

Behaviour:
- Reset (synchronous, active-high) sets all outputs to 0 except control = IDLE_CTRL. It also flushes the FIFO, sets state to IDLE and clears mismatch. Reset mid-game aborts with no result.
- FSM states: IDLE → LOAD → RUN → REPORT → IDLE.
  - IDLE: init=0, control=IDLE_CTRL. On start=1, latch seed and go to LOAD.
  - LOAD (exactly 1 cycle): init=1, initial_value=latched seed. Clear win_tally and lose_tally. Then go to RUN.
  - RUN: init=0. Each cycle:
    - FIFO non-empty: pop the head and register it onto control. Control therefore changes one cycle after the entry reaches the head.
    - FIFO empty: control=IDLE_CTRL.
    - winner=1: win_tally++. loser=1: lose_tally++. Both saturate at 15.
    - winner and loser both 1 in the same cycle: increment both and set mismatch.
    - gameover=1: capture who, go to REPORT. Pulses in that same cycle are still tallied.
  - REPORT (1 cycle):
    - result_valid=1, result_who=captured who.
    - who=10: games_won++. who=01: games_lost++. Both saturate at 255.
    - Set mismatch if any of:
      - who=01 and lose_tally≠TALLY_MAX
      - who=10 and win_tally≠TALLY_MAX
      - who ∈ {00,11}
    - Go to IDLE. Tallies hold their values until the next LOAD.
- winner, loser and gameover outside RUN are ignored. start outside IDLE is ignored.
- FIFO:
  - cmd_ready = !full && !reset. Push on cmd_valid && cmd_ready, in any state.
  - Pop only in RUN.
  - When full, no push even in a pop cycle (cmd_ready is based on full only).
  - Simultaneous push and pop when not full or empty: occupancy unchanged. Ordering is FIFO.
  - Pointers wrap modulo FIFO_DEPTH. The FIFO persists across games.
- mismatch is cleared only by reset.
- busy=1 in LOAD, RUN and REPORT.

Test Plan:
- Reset behaviour: assert reset 2 cycles while cmd_valid=1 → cmd_ready=0; all counters 0; control=00; init=0; busy=0. After release, cmd_ready=1.
- Seed load: seed=5, start pulse → init=1 for exactly one cycle with initial_value=5, two cycles after start. busy=1 from the cycle after start.
- Command order: push 01,10,11 before start → control shows 01,10,11 on consecutive RUN cycles, then 00.
- Backpressure: push 5 commands with no game running → cmd_ready=0 after 4 accepted. The 5th is held until the FIFO drains in RUN.
- Win path: drive 15 winner pulses, then gameover with who=10 → win_tally=15, result_valid for 1 cycle with result_who=10, games_won=1, mismatch=0.
- Mismatch: 3 loser pulses, then gameover with who=01 → result_valid, games_lost=1, mismatch=1 and stays set. Separately, winner and loser in the same cycle → mismatch=1. Reset mid-RUN → IDLE, no result_valid, tallies 0.
